x_input_shaper: RTL and testbench
=================================

X_INPUT_SHAPER -- requirements
Module: x_input_shaper

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable samples needed to accept a new button level.
REQ-002 The block SHALL have parameter PULSE_CYCLES, default 20000, meaning number of clk cycles an x output is held high per press.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 20000, meaning number of clk cycles x1=x2=0 is held after every pulse.
REQ-004 The block SHALL have port clk, input, 1, meaning the single system clock; all state is clocked on its rising edge.
REQ-005 The block SHALL have port rd, input, 1, meaning reset, asynchronous and active-low.
REQ-006 The block SHALL have port btn1, input, 1, meaning raw asynchronous push-button for x1, active-high.
REQ-007 The block SHALL have port btn2, input, 1, meaning raw asynchronous push-button for x2, active-high.
REQ-008 The block SHALL have port x1, output, 1, meaning registered shaped level for the downstream asynchronous machine.
REQ-009 The block SHALL have port x2, output, 1, meaning registered shaped level for the downstream asynchronous machine.
REQ-010 The block SHALL have port busy, output, 1, meaning high whenever the FSM is not IDLE.
REQ-011 The block SHALL have port collide, output, 1, meaning one-cycle pulse when both requests arrive in the same cycle.

Function
REQ-012 Each button SHALL pass through a 2-flop synchroniser, then a debouncer whose output changes only after DEBOUNCE_CYCLES consecutive equal synchronised samples.
REQ-013 A request SHALL be the 0->1 edge of a debounced level (one cycle wide); releases generate no request.
REQ-014 The FSM SHALL have states IDLE, P1, P2, GAP.
REQ-015 In IDLE, req1 alone SHALL move to P1 and req2 alone SHALL move to P2.
REQ-016 In IDLE, req1 and req2 together SHALL leave the FSM in IDLE and pulse collide for one cycle.
REQ-017 In P1/P2, the FSM SHALL move to GAP after exactly PULSE_CYCLES cycles.
REQ-018 In GAP, the FSM SHALL move to IDLE after exactly GAP_CYCLES cycles.
REQ-019 x1 SHALL be 1 only in P1 and x2 SHALL be 1 only in P2, so x1 and x2 are never both 1 and every transition changes at most one input.
REQ-020 x1/x2 SHALL rise on the first clk edge after the request cycle (latency 1) and stay high exactly PULSE_CYCLES cycles.
REQ-021 Requests arriving while not IDLE SHALL be discarded, with no queueing.
REQ-022 A parameter value of 0 SHALL behave as 1.
REQ-023 Each counter SHALL be $clog2(max(param,2)) bits wide, count down, and never wrap.

Reset
REQ-024 On rd=0, x1, x2, busy and collide SHALL become 0 immediately.
REQ-025 On rd=0, the FSM SHALL go to IDLE, all counters SHALL clear, and the synchroniser and debounced levels SHALL clear to 0.
REQ-026 Reset asserted mid-pulse SHALL abort the pulse with no GAP.
REQ-027 A button held through reset release SHALL produce one request after DEBOUNCE_CYCLES.

Configuration
REQ-028 With PULSE_COUNT_EN defined, the block SHALL add outputs cnt1[7:0] and cnt2[7:0], which increment on entry to P1/P2 respectively, wrap 255->0, and reset to 0.
REQ-029 Without PULSE_COUNT_EN, these ports and their logic SHALL be absent, with behaviour otherwise identical.

Structure
REQ-030 The state enum and the counter-width function SHALL reside in the shared package x_shaper_pkg.
REQ-031 Synchroniser plus debouncer SHALL be sub-module btn_debounce (ports clk, rd, din, dout, param DEBOUNCE_CYCLES), instantiated twice.

Verification (DEBOUNCE_CYCLES=4, PULSE_CYCLES=8, GAP_CYCLES=4)
REQ-032 btn1 high for 20 cycles -> x1=1 for exactly 8 cycles, then 00 for 4 cycles, busy=1 throughout, x2=0 throughout.
REQ-033 btn2 bouncing 1/0 every 2 cycles for 12 cycles, then stable 1 -> exactly one x2 pulse, starting after the stable window.
REQ-034 btn1 and btn2 rising in the same cycle -> collide=1 for one cycle, x1=x2=0, busy=0.
REQ-035 btn2 pressed during x1's pulse or GAP -> no x2 pulse; a later btn2 press in IDLE -> normal x2 pulse.
REQ-036 rd pulled low at pulse cycle 3 -> x1=0 asynchronously; after rd=1 with buttons low -> x1=x2=0, busy=0.
REQ-037 With PULSE_COUNT_EN: 257 btn1 presses -> cnt1=1, cnt2=0.

Source files
------------

// File: rtl/x_shaper_pkg.sv
// Shared definitions for the X input shaper: FSM state encoding and
// counter sizing helpers used by the shaper and its debouncers.
package x_shaper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2,
    GAP  = 2'd3
  } state_t;

  // A cycle-count parameter of zero is treated as one.
  function automatic int eff_cycles(input int p);
    return (p < 1) ? 1 : p;
  endfunction

  // Down-counter width: clog2 of the count, never narrower than one bit.
  function automatic int cnt_w(input int p);
    return $clog2((p < 2) ? 2 : p);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a down-counting debouncer. The output
// level only changes after DEBOUNCE_CYCLES consecutive synchronised samples
// that differ from the current output.
module btn_debounce
  import x_shaper_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rd,
  input  logic din,
  output logic dout
);

  localparam int DC = eff_cycles(DEBOUNCE_CYCLES);
  localparam int DW = cnt_w(DC);
  localparam logic [DW-1:0] DLOAD = DW'(DC - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [DW-1:0] cnt;

  // Decrement that holds at zero instead of wrapping.
  function automatic logic [DW-1:0] dec_sat(input logic [DW-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  // Synchroniser stages for the asynchronous button input.
  always_ff @(posedge clk or negedge rd) begin
    if (!rd) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: reload while the sample agrees with dout, count down while it
  // differs, accept the new level on the sample that finds the count at zero.
  always_ff @(posedge clk or negedge rd) begin
    if (!rd) begin
      dout <= 1'b0;
      cnt  <= '0;
    end else if (sync_p1 == dout) begin
      cnt <= DLOAD;
    end else if (cnt == '0) begin
      dout <= sync_p1;
      cnt  <= DLOAD;
    end else begin
      cnt <= dec_sat(cnt);
    end
  end

endmodule

// File: rtl/x_input_shaper.sv
// X input shaper: turns two raw push-buttons into clean, mutually exclusive
// fixed-width pulses on x1/x2, each followed by an all-zero gap, for a
// downstream asynchronous machine. Simultaneous requests are rejected and
// flagged on collide.
// Optional feature macro PULSE_COUNT_EN adds 8-bit pulse counters cnt1/cnt2.
module x_input_shaper
  import x_shaper_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PULSE_CYCLES    = 20000,
  parameter int GAP_CYCLES      = 20000
) (
  input  logic       clk,
  input  logic       rd,
  input  logic       btn1,
  input  logic       btn2,
  output logic       x1,
  output logic       x2,
  output logic       busy,
`ifdef PULSE_COUNT_EN
  output logic       collide,
  output logic [7:0] cnt1,
  output logic [7:0] cnt2
`else
  output logic       collide
`endif
);

  localparam int PC = eff_cycles(PULSE_CYCLES);
  localparam int GC = eff_cycles(GAP_CYCLES);
  localparam int PW = cnt_w(PC);
  localparam int GW = cnt_w(GC);
  localparam logic [PW-1:0] PLOAD = PW'(PC - 1);
  localparam logic [GW-1:0] GLOAD = GW'(GC - 1);

  logic          deb1, deb2;
  logic          deb1_d, deb2_d;
  logic          req1, req2;
  state_t        state, state_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic          coll_n;

  function automatic logic [PW-1:0] dec_p(input logic [PW-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  function automatic logic [GW-1:0] dec_g(input logic [GW-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
    .clk  (clk),
    .rd   (rd),
    .din  (btn1),
    .dout (deb1)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb2 (
    .clk  (clk),
    .rd   (rd),
    .din  (btn2),
    .dout (deb2)
  );

  // Delayed debounced levels for rising-edge request detection.
  always_ff @(posedge clk or negedge rd) begin
    if (!rd) begin
      deb1_d <= 1'b0;
      deb2_d <= 1'b0;
    end else begin
      deb1_d <= deb1;
      deb2_d <= deb2;
    end
  end

  assign req1 = deb1 & ~deb1_d;
  assign req2 = deb2 & ~deb2_d;

  // Next-state logic; requests outside IDLE are simply ignored.
  always_comb begin
    state_n = state;
    pcnt_n  = pcnt;
    gcnt_n  = gcnt;
    coll_n  = 1'b0;
    case (state)
      IDLE: begin
        if (req1 && req2) begin
          coll_n = 1'b1;
        end else if (req1) begin
          state_n = P1;
          pcnt_n  = PLOAD;
        end else if (req2) begin
          state_n = P2;
          pcnt_n  = PLOAD;
        end
      end
      P1, P2: begin
        if (pcnt == '0) begin
          state_n = GAP;
          gcnt_n  = GLOAD;
        end else begin
          pcnt_n = dec_p(pcnt);
        end
      end
      GAP: begin
        if (gcnt == '0) begin
          state_n = IDLE;
        end else begin
          gcnt_n = dec_g(gcnt);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters and glitch-free registered outputs.
  always_ff @(posedge clk or negedge rd) begin
    if (!rd) begin
      state   <= IDLE;
      pcnt    <= '0;
      gcnt    <= '0;
      x1      <= 1'b0;
      x2      <= 1'b0;
      busy    <= 1'b0;
      collide <= 1'b0;
    end else begin
      state   <= state_n;
      pcnt    <= pcnt_n;
      gcnt    <= gcnt_n;
      x1      <= (state_n == P1);
      x2      <= (state_n == P2);
      busy    <= (state_n != IDLE);
      collide <= coll_n;
    end
  end

`ifdef PULSE_COUNT_EN
  // Pulse counters advance on entry to P1/P2 and wrap naturally at 8 bits.
  always_ff @(posedge clk or negedge rd) begin
    if (!rd) begin
      cnt1 <= 8'd0;
      cnt2 <= 8'd0;
    end else begin
      if (state == IDLE && state_n == P1) cnt1 <= cnt1 + 8'd1;
      if (state == IDLE && state_n == P2) cnt2 <= cnt2 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_x_input_shaper.sv
// Scoreboard bench for x_input_shaper (DEBOUNCE=4, PULSE=8, GAP=4).
// A button edge driven at cycle c shows up on x1/x2 at cycle c+7:
// 2 synchroniser cycles + 4 debounce samples + 1 request-to-output cycle.
module tb_x_input_shaper;

  localparam int LAT = 7;

  logic clk = 1'b0;
  logic rd, btn1, btn2;
  logic x1, x2, busy, collide;
`ifdef PULSE_COUNT_EN
  logic [7:0] cnt1, cnt2;
`endif

  x_input_shaper #(
    .DEBOUNCE_CYCLES(4),
    .PULSE_CYCLES   (8),
    .GAP_CYCLES     (4)
  ) dut (
    .clk     (clk),
    .rd      (rd),
    .btn1    (btn1),
    .btn2    (btn2),
    .x1      (x1),
    .x2      (x2),
    .busy    (busy),
`ifdef PULSE_COUNT_EN
    .collide (collide),
    .cnt1    (cnt1),
    .cnt2    (cnt2)
`else
    .collide (collide)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 1 = x1 pulse, 2 = x2 pulse, 3 = collide pulse
  typedef struct {
    int kind;
    int start;
    int len;
    int gap;
  } ev_t;

  ev_t expq[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int k, input int s, input int l, input int g);
    ev_t e;
    e.kind = k; e.start = s; e.len = l; e.gap = g;
    expq.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor state
  int mst = 0, mkind = 0, mstart = 0, mlen = 0, mgap = 0;
  bit mok = 1'b1;

  task automatic close_ev();
    ev_t e;
    if (expq.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d start=%0d len=%0d gap=%0d, expected none",
               mkind, mstart, mlen, mgap);
    end else begin
      e = expq.pop_front();
      chk("ev_kind",  mkind,  e.kind);
      chk("ev_start", mstart, e.start);
      chk("ev_len",   mlen,   e.len);
      chk("ev_gap",   mgap,   e.gap);
      chk("ev_excl_busy", int'(mok), 1);
    end
    mst = 0;
  endtask

  // Monitor: measures each output event and checks it against the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (mst == 1) begin
        if ((mkind == 1 && x1) || (mkind == 2 && x2)) begin
          mlen++;
          if ((x1 && x2) || !busy) mok = 1'b0;
        end else if (busy && !x1 && !x2) begin
          mst  = 2;
          mgap = 1;
        end else begin
          close_ev();
        end
      end else if (mst == 2) begin
        if (busy && !x1 && !x2) mgap++;
        else close_ev();
      end else if (mst == 3) begin
        if (collide) mlen++;
        else close_ev();
      end
      if (mst == 0) begin
        if (x1 || x2) begin
          mst = 1; mkind = x1 ? 1 : 2; mstart = cyc; mlen = 1; mgap = 0;
          mok = !(x1 && x2) && busy;
        end else if (collide) begin
          mst = 3; mkind = 3; mstart = cyc; mlen = 1; mgap = 0;
          mok = !busy;
        end
      end
    end
  end

  // Stimulus
  initial begin
    int c;
    rd = 1'b0; btn1 = 1'b0; btn2 = 1'b0;
    wait_cyc(3);
    chk("rst_x1", int'(x1), 0);
    chk("rst_x2", int'(x2), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_collide", int'(collide), 0);
    rd = 1'b1;
    wait_cyc(10);

    // Single x1 press held 20 cycles
    c = cyc; btn1 = 1'b1; push(1, c + LAT, 8, 4);
    wait_cyc(20); btn1 = 1'b0;
    wait_cyc(40);

    // Bouncing btn2 then stable: one pulse after the stable window
    c = cyc;
    for (int i = 0; i < 12; i++) begin
      btn2 = (((i / 2) % 2) == 0);
      wait_cyc(1);
    end
    btn2 = 1'b1; push(2, c + 12 + LAT, 8, 4);
    wait_cyc(20); btn2 = 1'b0;
    wait_cyc(40);

    // Simultaneous presses
    c = cyc; btn1 = 1'b1; btn2 = 1'b1; push(3, c + LAT, 1, 0);
    wait_cyc(20); btn1 = 1'b0; btn2 = 1'b0;
    wait_cyc(40);

    // btn2 during x1 pulse is discarded
    c = cyc; btn1 = 1'b1; push(1, c + LAT, 8, 4);
    wait_cyc(2); btn2 = 1'b1;
    wait_cyc(10); btn1 = 1'b0;
    wait_cyc(2); btn2 = 1'b0;
    wait_cyc(40);

    // btn2 whose request lands in GAP is discarded
    c = cyc; btn1 = 1'b1; push(1, c + LAT, 8, 4);
    wait_cyc(10); btn2 = 1'b1;
    wait_cyc(14); btn1 = 1'b0; btn2 = 1'b0;
    wait_cyc(40);

    // Later btn2 press in IDLE works normally
    c = cyc; btn2 = 1'b1; push(2, c + LAT, 8, 4);
    wait_cyc(20); btn2 = 1'b0;
    wait_cyc(40);

    // Reset at pulse cycle 3 aborts the pulse with no gap
    c = cyc; btn1 = 1'b1; push(1, c + LAT, 3, 0);
    wait_cyc(LAT + 2);
    #2 rd = 1'b0; btn1 = 1'b0;
    #1;
    chk("async_rst_x1", int'(x1), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_x2", int'(x2), 0);
    wait_cyc(3); rd = 1'b1;
    wait_cyc(30);
    chk("post_rst_x1", int'(x1), 0);
    chk("post_rst_x2", int'(x2), 0);
    chk("post_rst_busy", int'(busy), 0);

    // Button held through reset release gives one request
    rd = 1'b0; btn1 = 1'b1;
    wait_cyc(3);
    c = cyc; rd = 1'b1; push(1, c + LAT, 8, 4);
    wait_cyc(20); btn1 = 1'b0;
    wait_cyc(40);

`ifdef PULSE_COUNT_EN
    rd = 1'b0;
    wait_cyc(2);
    chk("cnt1_rst", int'(cnt1), 0);
    rd = 1'b1;
    wait_cyc(4);
    for (int i = 0; i < 257; i++) begin
      c = cyc; btn1 = 1'b1; push(1, c + LAT, 8, 4);
      wait_cyc(20); btn1 = 1'b0;
      wait_cyc(12);
    end
    wait_cyc(20);
    chk("cnt1_wrap", int'(cnt1), 1);
    chk("cnt2_zero", int'(cnt2), 0);
`endif

    for (int i = 0; i < 200 && (expq.size() != 0 || mst != 0); i++) @(negedge clk);
    chk("drain_pending", expq.size() + mst, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
